// File: rtl/uart_pkg.sv
// Shared constants for the buffered uart front end: core and CPU register
// addresses, status/interrupt-enable bit positions and engine FSM states.
package uart_pkg;

    // Core register map, as driven by this block
    localparam logic [3:0] CORE_RX     = 4'd0;
    localparam logic [3:0] CORE_TX     = 4'd1;
    localparam logic [3:0] CORE_STAT   = 4'd2;
    localparam logic [3:0] CORE_DIV_LO = 4'd4;
    localparam logic [3:0] CORE_DIV_HI = 4'd5;

    // Bit positions inside the core status register
    localparam int CORE_TX_FLAG = 0;
    localparam int CORE_RX_FLAG = 1;

    // CPU-facing register map
    localparam logic [3:0] CPU_RX     = 4'd0;
    localparam logic [3:0] CPU_TX     = 4'd1;
    localparam logic [3:0] CPU_STAT   = 4'd2;
    localparam logic [3:0] CPU_IE     = 4'd3;
    localparam logic [3:0] CPU_DIV_LO = 4'd4;
    localparam logic [3:0] CPU_DIV_HI = 4'd5;

    // CPU status register bit positions
    localparam int ST_RX_AVAIL = 0;
    localparam int ST_TX_IDLE  = 1;
    localparam int ST_TX_FULL  = 2;
    localparam int ST_TX_OVF   = 3;
    localparam int ST_RX_OVR   = 4;

    // Interrupt-enable bit positions
    localparam int IE_RX_AVAIL = 0;
    localparam int IE_TX_IDLE  = 1;
    localparam int IE_ERROR    = 2;

    // Engine FSM states
    localparam logic [0:0] S_POLL = 1'b0;
    localparam logic [0:0] S_ACT  = 1'b1;

    // Addresses whose accesses are handed straight through to the core
    function automatic logic is_core_window(input logic [3:0] addr);
        return (addr == CPU_DIV_LO) || (addr == CPU_DIV_HI);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a combinational head (first-word fall-through).
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      din,
    output logic [WIDTH-1:0]      head,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_reg;
    logic [DEPTH_LOG2-1:0] rd_ptr_reg;
    logic [DEPTH_LOG2:0]   count_reg;
    logic                  do_push;
    logic                  do_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == {1'b1, {DEPTH_LOG2{1'b0}}});
    assign count   = count_reg;
    assign head    = mem[rd_ptr_reg];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    // Storage write; no reset so the array maps onto RAM
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= din;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + DEPTH_LOG2'(1);
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + DEPTH_LOG2'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + (DEPTH_LOG2+1)'(1);
                2'b01:   count_reg <= count_reg - (DEPTH_LOG2+1)'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/uart_fifo.sv
// Buffered CPU front end for the uart core. Owns the core register port:
// a two-state engine alternately polls core status and moves one byte
// (RX capture, TX write or TX-done clear). CPU divisor accesses steal the
// port for one cycle and freeze the engine.
module uart_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic       clk,
    input  logic       reset,
    output logic       interrupt,
    input  logic [3:0] cpu_addr,
    input  logic [7:0] cpu_wdata,
    input  logic       cpu_write,
    input  logic       cpu_read,
    output logic [7:0] cpu_rdata,
    output logic [3:0] u_addr,
    output logic [7:0] u_wdata,
    output logic       u_write,
    output logic       u_read,
    input  logic [7:0] u_rdata
);

    logic [0:0]          state_reg, state_next;
    logic                st_rx_reg, st_rx_next;
    logic                st_tx_reg, st_tx_next;
    logic                tx_busy_reg, tx_busy_next;
    logic                rx_ovr_reg, tx_ovf_reg;
    logic [2:0]          ie_reg;

    logic                cpu_pass;
    logic                tx_push, eng_tx_pop;
    logic                eng_rx_push, rx_pop;
    logic [7:0]          tx_head, rx_head;
    logic                tx_full, tx_empty, rx_full, rx_empty;
    logic [DEPTH_LOG2:0] tx_count, rx_count;
    logic                tx_drop, rx_drop;
    logic                tx_idle, rx_avail;
    logic [7:0]          status;

    assign cpu_pass = (cpu_read | cpu_write) & is_core_window(cpu_addr);
    assign tx_push  = cpu_write & (cpu_addr == CPU_TX);
    assign rx_pop   = cpu_read & (cpu_addr == CPU_RX);

    sync_fifo #(.WIDTH(8), .DEPTH_LOG2(DEPTH_LOG2)) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tx_push),
        .pop   (eng_tx_pop),
        .din   (cpu_wdata),
        .head  (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    sync_fifo #(.WIDTH(8), .DEPTH_LOG2(DEPTH_LOG2)) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (eng_rx_push),
        .pop   (rx_pop),
        .din   (u_rdata),
        .head  (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    // A same-cycle pop frees a slot, so only a push without one overflows
    assign tx_drop  = tx_push & tx_full & ~eng_tx_pop;
    assign rx_drop  = eng_rx_push & rx_full & ~rx_pop;
    assign tx_idle  = (tx_count == '0) & ~tx_busy_reg;
    assign rx_avail = (rx_count != '0);
    assign status   = {3'b000, rx_ovr_reg, tx_ovf_reg, tx_full, tx_idle, rx_avail};

    assign interrupt = |(ie_reg & {rx_ovr_reg | tx_ovf_reg, tx_idle, rx_avail});

    // Core port arbitration and engine next-state: one core access per cycle
    always_comb begin
        state_next   = state_reg;
        st_rx_next   = st_rx_reg;
        st_tx_next   = st_tx_reg;
        tx_busy_next = tx_busy_reg;
        u_addr       = CORE_STAT;
        u_wdata      = 8'h00;
        u_write      = 1'b0;
        u_read       = 1'b0;
        eng_tx_pop   = 1'b0;
        eng_rx_push  = 1'b0;
        if (cpu_pass) begin
            u_addr  = cpu_addr;
            u_wdata = cpu_wdata;
            u_write = cpu_write;
            u_read  = cpu_read;
        end else if (state_reg == S_POLL) begin
            st_rx_next = u_rdata[CORE_RX_FLAG];
            st_tx_next = u_rdata[CORE_TX_FLAG];
            state_next = S_ACT;
        end else begin
            state_next = S_POLL;
            if (st_rx_reg) begin
                u_addr      = CORE_RX;
                u_read      = 1'b1;
                eng_rx_push = 1'b1;
            end else if (st_tx_reg && tx_busy_reg && !tx_empty) begin
                u_addr     = CORE_TX;
                u_wdata    = tx_head;
                u_write    = 1'b1;
                eng_tx_pop = 1'b1;
            end else if (st_tx_reg && tx_busy_reg) begin
                // Last byte has gone out: acknowledge the tx flag and go idle
                u_addr       = CORE_STAT;
                u_wdata      = 8'h01;
                u_write      = 1'b1;
                tx_busy_next = 1'b0;
            end else if (!tx_busy_reg && !tx_empty) begin
                u_addr       = CORE_TX;
                u_wdata      = tx_head;
                u_write      = 1'b1;
                eng_tx_pop   = 1'b1;
                tx_busy_next = 1'b1;
            end
        end
    end

    // Engine state registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= S_POLL;
            st_rx_reg   <= 1'b0;
            st_tx_reg   <= 1'b0;
            tx_busy_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            st_rx_reg   <= st_rx_next;
            st_tx_reg   <= st_tx_next;
            tx_busy_reg <= tx_busy_next;
        end
    end

    // Sticky error flags and interrupt enables; a new error beats a clear
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_ovr_reg <= 1'b0;
            tx_ovf_reg <= 1'b0;
            ie_reg     <= 3'b000;
        end else begin
            if (tx_drop) begin
                tx_ovf_reg <= 1'b1;
            end else if (cpu_write && cpu_addr == CPU_STAT && cpu_wdata[ST_TX_OVF]) begin
                tx_ovf_reg <= 1'b0;
            end
            if (rx_drop) begin
                rx_ovr_reg <= 1'b1;
            end else if (cpu_write && cpu_addr == CPU_STAT && cpu_wdata[ST_RX_OVR]) begin
                rx_ovr_reg <= 1'b0;
            end
            if (cpu_write && cpu_addr == CPU_IE) begin
                ie_reg <= cpu_wdata[2:0];
            end
        end
    end

    // CPU read mux
    always_comb begin
        cpu_rdata = 8'h00;
        case (cpu_addr)
            CPU_RX:     cpu_rdata = rx_empty ? 8'h00 : rx_head;
            CPU_STAT:   cpu_rdata = status;
            CPU_IE:     cpu_rdata = {5'b00000, ie_reg};
            CPU_DIV_LO: cpu_rdata = u_rdata;
            CPU_DIV_HI: cpu_rdata = u_rdata;
            default:    cpu_rdata = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_uart_fifo.sv
// Directed bench for uart_fifo with a behavioural uart core model on the
// core register port. Inputs change on the falling edge, outputs are sampled
// there too.
module tb_uart_fifo;

    logic       clk = 1'b0;
    logic       reset;
    logic       interrupt;
    logic [3:0] cpu_addr;
    logic [7:0] cpu_wdata;
    logic       cpu_write;
    logic       cpu_read;
    logic [7:0] cpu_rdata;
    logic [3:0] u_addr;
    logic [7:0] u_wdata;
    logic       u_write;
    logic       u_read;
    logic [7:0] u_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    uart_fifo #(.DEPTH_LOG2(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .interrupt (interrupt),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_write (cpu_write),
        .cpu_read  (cpu_read),
        .cpu_rdata (cpu_rdata),
        .u_addr    (u_addr),
        .u_wdata   (u_wdata),
        .u_write   (u_write),
        .u_read    (u_read),
        .u_rdata   (u_rdata)
    );

    // ---------------- core model ----------------
    logic       core_rx_flag = 1'b0;
    logic       core_tx_flag = 1'b0;
    logic [7:0] core_rx_data = 8'h00;
    logic [7:0] core_div_lo  = 8'h00;
    logic [7:0] core_div_hi  = 8'h00;
    int         tx_timer     = 0;
    int         tx_delay     = 4;
    bit         tx_hold      = 1'b0;
    bit         rx_inject    = 1'b0;
    logic [7:0] rx_inject_data = 8'h00;
    logic [7:0] tx_log [64];
    int         tx_cyc_log [64];
    int         tx_cnt   = 0;
    int         clr_cnt  = 0;
    logic [7:0] clr_data = 8'h00;
    int         rd_cnt   = 0;
    int         rd_cyc   = 0;
    int         cyc      = 0;

    always_comb begin
        u_rdata = 8'h00;
        case (u_addr)
            4'd0:    u_rdata = core_rx_data;
            4'd2:    u_rdata = {6'b000000, core_rx_flag, core_tx_flag};
            4'd4:    u_rdata = core_div_lo;
            4'd5:    u_rdata = core_div_hi;
            default: u_rdata = 8'h00;
        endcase
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            core_rx_flag <= 1'b0;
            core_tx_flag <= 1'b0;
            tx_timer     <= 0;
            core_div_lo  <= 8'h00;
            core_div_hi  <= 8'h00;
        end else begin
            if (tx_timer != 0 && !tx_hold) begin
                tx_timer <= tx_timer - 1;
                if (tx_timer == 1) core_tx_flag <= 1'b1;
            end
            if (rx_inject) begin
                core_rx_flag <= 1'b1;
                core_rx_data <= rx_inject_data;
            end
            if (u_read && u_addr == 4'd0) begin
                core_rx_flag <= 1'b0;
                rd_cnt       <= rd_cnt + 1;
                rd_cyc       <= cyc;
            end
            if (u_write) begin
                case (u_addr)
                    4'd1: begin
                        if (tx_cnt < 64) begin
                            tx_log[tx_cnt]     <= u_wdata;
                            tx_cyc_log[tx_cnt] <= cyc;
                        end
                        tx_cnt       <= tx_cnt + 1;
                        core_tx_flag <= 1'b0;
                        tx_timer     <= tx_delay;
                    end
                    4'd2: begin
                        if (u_wdata[0]) core_tx_flag <= 1'b0;
                        if (u_wdata[1]) core_rx_flag <= 1'b0;
                        clr_cnt  <= clr_cnt + 1;
                        clr_data <= u_wdata;
                    end
                    4'd4: core_div_lo <= u_wdata;
                    4'd5: core_div_hi <= u_wdata;
                    default: ;
                endcase
            end
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-22s observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic cpu_wr(input logic [3:0] a, input logic [7:0] d);
        cpu_addr  = a;
        cpu_wdata = d;
        cpu_write = 1'b1;
        @(negedge clk);
        cpu_write = 1'b0;
    endtask

    task automatic cpu_rd(input logic [3:0] a, output logic [7:0] d);
        cpu_addr = a;
        cpu_read = 1'b1;
        #1 d = cpu_rdata;
        @(negedge clk);
        cpu_read = 1'b0;
    endtask

    task automatic peek(input logic [3:0] a, output logic [7:0] d);
        cpu_addr = a;
        #1 d = cpu_rdata;
    endtask

    task automatic inject(input logic [7:0] d);
        rx_inject_data = d;
        rx_inject      = 1'b1;
        @(negedge clk);
        rx_inject      = 1'b0;
    endtask

    task automatic wait_tx(input int target, input int budget);
        for (int i = 0; i < budget && tx_cnt < target; i++) @(negedge clk);
    endtask

    task automatic wait_clr(input int target, input int budget);
        for (int i = 0; i < budget && clr_cnt < target; i++) @(negedge clk);
    endtask

    task automatic wait_rd(input int target, input int budget);
        for (int i = 0; i < budget && rd_cnt < target; i++) @(negedge clk);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [7:0] d;
        int         push_cyc;
        int         inj_cyc;
        int         base;

        reset     = 1'b1;
        cpu_addr  = 4'd0;
        cpu_wdata = 8'h00;
        cpu_write = 1'b0;
        cpu_read  = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_interrupt", interrupt, 1'b0);
        check("rst_u_write", u_write, 1'b0);
        check("rst_u_read", u_read, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        peek(4'd2, d); check("rst_status", d, 8'h02);
        peek(4'd3, d); check("rst_ie", d, 8'h00);
        peek(4'd0, d); check("rst_rx_empty_read", d, 8'h00);

        // Single byte: reaches the core within two cycles, then idles again
        cpu_wr(4'd1, 8'h55);
        push_cyc = cyc - 1;
        wait_tx(1, 10);
        check("tx55_count", tx_cnt, 1);
        check("tx55_byte", tx_log[0], 8'h55);
        check("tx55_latency_le2", (tx_cyc_log[0] - push_cyc) <= 2, 1'b1);
        peek(4'd2, d); check("tx55_busy_status", d, 8'h00);
        wait_clr(1, 40);
        check("tx55_clr_count", clr_cnt, 1);
        check("tx55_clr_data", clr_data, 8'h01);
        peek(4'd2, d); check("tx55_idle_status", d, 8'h02);

        // Three bytes: each follow-on byte waits for the core's tx flag
        cpu_wr(4'd1, 8'hA1);
        cpu_wr(4'd1, 8'hA2);
        cpu_wr(4'd1, 8'hA3);
        wait_tx(4, 100);
        check("tx3_count", tx_cnt, 4);
        check("tx3_b1", tx_log[1], 8'hA1);
        check("tx3_b2", tx_log[2], 8'hA2);
        check("tx3_b3", tx_log[3], 8'hA3);
        check("tx3_gap_after_flag", (tx_cyc_log[2] - tx_cyc_log[1]) > tx_delay, 1'b1);
        wait_clr(2, 60);
        check("tx3_clr_data", clr_data, 8'h01);
        peek(4'd2, d); check("tx3_idle_status", d, 8'h02);

        // Overflow: core held busy, 16 of 17 pushes kept
        tx_hold = 1'b1;
        cpu_wr(4'd1, 8'hF0);
        wait_tx(5, 10);
        check("ovf_first_to_core", tx_log[4], 8'hF0);
        for (int i = 0; i < 17; i++) cpu_wr(4'd1, 8'h10 + 8'(i));
        peek(4'd2, d); check("ovf_status", d, 8'h0C);
        cpu_wr(4'd2, 8'h08);
        peek(4'd2, d); check("ovf_cleared_status", d, 8'h04);
        tx_hold = 1'b0;
        wait_tx(21, 500);
        check("ovf_drain_count", tx_cnt, 21);
        for (int i = 0; i < 16; i++) check("ovf_drain_byte", tx_log[5 + i], 8'h10 + 8'(i));
        wait_clr(3, 60);
        peek(4'd2, d); check("ovf_idle_status", d, 8'h02);
        cpu_wr(4'd3, 8'h02);
        check("irq_tx_idle", interrupt, 1'b1);
        cpu_wr(4'd3, 8'h00);
        check("irq_masked", interrupt, 1'b0);

        // Single RX byte
        inject(8'h3C);
        inj_cyc = cyc - 1;
        wait_rd(1, 10);
        check("rx3c_core_read", rd_cnt, 1);
        check("rx3c_latency", (rd_cyc - inj_cyc) <= 3, 1'b1);
        peek(4'd2, d); check("rx3c_status", d, 8'h03);
        cpu_rd(4'd0, d); check("rx3c_data", d, 8'h3C);
        peek(4'd2, d); check("rx3c_popped_status", d, 8'h02);

        // RX overrun: 17 bytes, no pops
        for (int i = 0; i < 17; i++) begin
            inject(8'h80 + 8'(i));
            wait_rd(2 + i, 12);
        end
        check("rxovr_core_reads", rd_cnt, 18);
        peek(4'd2, d); check("rxovr_status", d, 8'h13);
        cpu_wr(4'd3, 8'h04);
        check("rxovr_irq_error", interrupt, 1'b1);
        peek(4'd3, d); check("rxovr_ie_readback", d, 8'h04);
        for (int i = 0; i < 16; i++) begin
            cpu_rd(4'd0, d);
            check("rxovr_order", d, 8'h80 + 8'(i));
        end
        peek(4'd0, d); check("rxovr_empty_read", d, 8'h00);
        peek(4'd2, d); check("rxovr_sticky_status", d, 8'h12);
        cpu_wr(4'd2, 8'h10);
        check("rxovr_irq_cleared", interrupt, 1'b0);
        peek(4'd2, d); check("rxovr_cleared_status", d, 8'h02);
        cpu_wr(4'd3, 8'h00);

        // Divisor write while an RX byte is pending: both get through
        inject(8'h77);
        inj_cyc = cyc - 1;
        cpu_wr(4'd4, 8'h0A);
        check("div_lo_written", core_div_lo, 8'h0A);
        wait_rd(19, 12);
        check("div_rx_core_reads", rd_cnt, 19);
        check("div_rx_latency", (rd_cyc - inj_cyc) <= 4, 1'b1);
        cpu_wr(4'd5, 8'h01);
        check("div_hi_written", core_div_hi, 8'h01);
        cpu_rd(4'd4, d); check("div_lo_readback", d, 8'h0A);
        cpu_rd(4'd0, d); check("div_rx_data", d, 8'h77);

        // Reset mid-byte discards queued TX data
        tx_hold = 1'b1;
        cpu_wr(4'd1, 8'hAA);
        cpu_wr(4'd1, 8'hBB);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset   = 1'b0;
        tx_hold = 1'b0;
        base    = tx_cnt;
        peek(4'd2, d); check("midrst_status", d, 8'h02);
        repeat (30) @(negedge clk);
        check("midrst_no_tx", tx_cnt, base);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end of the sequence");
        $fatal(1, "timeout");
    end

endmodule
